// File: rtl/bp_clint_nhart.sv
// bp_clint_nhart: core-local interruptor for harts_p harts.
//
// Registers (byte offsets within the device):
//   0x0000 + 4h : msip[h]      4B only, bit 0 stored
//   0x4000 + 8h : mtimecmp[h]  8B, or 4B halves at +0 / +4
//   0xBFF8      : mtime        8B, or 4B halves at +0 / +4
//   0xC000 + 4h : meip[h]      4B only, bit 0 stored
//
// Ports:
//   clk_i, reset_i           clock, synchronous active-high reset
//   cmd_v_i/cmd_ready_and_o  command handshake
//   cmd_w_i, cmd_addr_i,     write flag, byte offset,
//   cmd_size_i, cmd_data_i   size (2=4B, 3=8B), LSB-aligned write data
//   resp_v_o/resp_yumi_i     response handshake
//   resp_data_o, resp_err_o  read data (0 on writes/errors), error flag
//   software_irq_o, timer_irq_o, external_irq_o  per-hart interrupt lines
//
// Handshake: a command is accepted on a rising edge where
// cmd_v_i & cmd_ready_and_o. A single response register holds the result,
// valid from the cycle after acceptance until the edge where resp_yumi_i is
// high. Ready is ~resp_v | resp_yumi_i, so a consumed response makes room
// for a new command in the same cycle (one command per cycle sustained).
module bp_clint_nhart #(
  parameter int harts_p    = 4,
  parameter int ds_ratio_p = 8
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               cmd_v_i,
  output logic               cmd_ready_and_o,
  input  logic               cmd_w_i,
  input  logic [15:0]        cmd_addr_i,
  input  logic [1:0]         cmd_size_i,
  input  logic [63:0]        cmd_data_i,
  output logic               resp_v_o,
  input  logic               resp_yumi_i,
  output logic [63:0]        resp_data_o,
  output logic               resp_err_o,
  output logic [harts_p-1:0] software_irq_o,
  output logic [harts_p-1:0] timer_irq_o,
  output logic [harts_p-1:0] external_irq_o
);

  localparam logic [7:0]  presc_last_lp = 8'(ds_ratio_p - 1);
  localparam logic [11:0] harts_w_lp    = 12'(harts_p);
  localparam logic [10:0] harts_d_lp    = 11'(harts_p);

  // Architectural state
  logic [63:0]        mtime_q, mtime_d;
  logic [7:0]         presc_q, presc_d;
  logic [63:0]        mtimecmp_q [harts_p];
  logic [63:0]        mtimecmp_d [harts_p];
  logic [harts_p-1:0] msip_q, msip_d;
  logic [harts_p-1:0] meip_q, meip_d;

  // Response register
  logic               resp_v_q, resp_v_d;
  logic [63:0]        resp_data_q, resp_data_d;
  logic               resp_err_q, resp_err_d;

  // Decode
  logic [11:0] word_idx;   // hart index for 4B-strided msip/meip
  logic [10:0] dword_idx;  // hart index for 8B-strided mtimecmp
  logic        is8, size_ok, align_ok, hi_half;
  logic        hit_msip, hit_cmp, hit_mtime, hit_meip;
  logic        dec_err, accept, wr_en, tick;
  logic [63:0] rd_data, reg64;
  logic        msip_bit, meip_bit;

  function automatic logic [63:0] merge_w(input logic [63:0] old_val,
                                          input logic [63:0] wdata,
                                          input logic        full,
                                          input logic        hi);
    if (full)    return wdata;
    else if (hi) return {wdata[31:0], old_val[31:0]};
    else         return {old_val[63:32], wdata[31:0]};
  endfunction

  assign cmd_ready_and_o = ~reset_i & (~resp_v_q | resp_yumi_i);
  assign accept          = cmd_v_i & cmd_ready_and_o;
  assign tick            = (presc_q == presc_last_lp);

  assign word_idx  = cmd_addr_i[13:2];
  assign dword_idx = cmd_addr_i[13:3];
  assign is8       = (cmd_size_i == 2'd3);
  assign size_ok   = cmd_size_i[1];
  assign align_ok  = is8 ? (cmd_addr_i[2:0] == 3'b000) : (cmd_addr_i[1:0] == 2'b00);
  assign hi_half   = cmd_addr_i[2];

  // 8B accesses are only meaningful for the 64-bit registers
  assign hit_msip  = (cmd_addr_i[15:14] == 2'b00) && (word_idx < harts_w_lp) && !is8;
  assign hit_cmp   = (cmd_addr_i[15:14] == 2'b01) && (dword_idx < harts_d_lp);
  assign hit_mtime = (cmd_addr_i[15:3] == 13'h17FF);
  assign hit_meip  = (cmd_addr_i[15:14] == 2'b11) && (word_idx < harts_w_lp) && !is8;

  assign dec_err = ~(size_ok & align_ok & (hit_msip | hit_cmp | hit_mtime | hit_meip));
  assign wr_en   = accept & cmd_w_i & ~dec_err;

  // Read mux: reflects register contents before this edge's write
  always_comb begin
    reg64    = '0;
    msip_bit = 1'b0;
    meip_bit = 1'b0;
    rd_data  = '0;
    for (int h = 0; h < harts_p; h++) begin
      if (dword_idx == 11'(h)) reg64 = mtimecmp_q[h];
      if (word_idx == 12'(h)) begin
        msip_bit = msip_q[h];
        meip_bit = meip_q[h];
      end
    end
    if (hit_mtime) reg64 = mtime_q;
    if (hit_msip)      rd_data = {63'b0, msip_bit};
    else if (hit_meip) rd_data = {63'b0, meip_bit};
    else if (is8)      rd_data = reg64;
    else if (hi_half)  rd_data = {32'b0, reg64[63:32]};
    else               rd_data = {32'b0, reg64[31:0]};
  end

  // Next-state logic
  always_comb begin
    presc_d = tick ? 8'd0 : presc_q + 8'd1;
    mtime_d = tick ? mtime_q + 64'd1 : mtime_q;
    // A software write to mtime overrides the increment of the same cycle
    if (wr_en && hit_mtime) mtime_d = merge_w(mtime_q, cmd_data_i, is8, hi_half);

    msip_d = msip_q;
    meip_d = meip_q;
    for (int h = 0; h < harts_p; h++) begin
      mtimecmp_d[h] = mtimecmp_q[h];
      if (wr_en && hit_cmp && (dword_idx == 11'(h)))
        mtimecmp_d[h] = merge_w(mtimecmp_q[h], cmd_data_i, is8, hi_half);
      if (wr_en && hit_msip && (word_idx == 12'(h))) msip_d[h] = cmd_data_i[0];
      if (wr_en && hit_meip && (word_idx == 12'(h))) meip_d[h] = cmd_data_i[0];
    end

    resp_v_d    = resp_v_q;
    resp_data_d = resp_data_q;
    resp_err_d  = resp_err_q;
    if (accept) begin
      resp_v_d    = 1'b1;
      resp_data_d = (cmd_w_i | dec_err) ? 64'd0 : rd_data;
      resp_err_d  = dec_err;
    end else if (resp_yumi_i) begin
      resp_v_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      mtime_q     <= '0;
      presc_q     <= '0;
      msip_q      <= '0;
      meip_q      <= '0;
      resp_v_q    <= 1'b0;
      resp_data_q <= '0;
      resp_err_q  <= 1'b0;
      for (int h = 0; h < harts_p; h++) mtimecmp_q[h] <= '1;
    end else begin
      mtime_q     <= mtime_d;
      presc_q     <= presc_d;
      msip_q      <= msip_d;
      meip_q      <= meip_d;
      resp_v_q    <= resp_v_d;
      resp_data_q <= resp_data_d;
      resp_err_q  <= resp_err_d;
      for (int h = 0; h < harts_p; h++) mtimecmp_q[h] <= mtimecmp_d[h];
    end
  end

  assign resp_v_o    = resp_v_q;
  assign resp_data_o = resp_data_q;
  assign resp_err_o  = resp_err_q;

  always_comb begin
    for (int h = 0; h < harts_p; h++) timer_irq_o[h] = (mtime_q >= mtimecmp_q[h]);
  end
  assign software_irq_o = msip_q;
  assign external_irq_o = meip_q;

endmodule

// File: tb/tb_bp_clint_nhart.sv
module tb_bp_clint_nhart;

  localparam int H  = 4;
  localparam int DS = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          cmd_v_i = 1'b0;
  logic          cmd_ready_and_o;
  logic          cmd_w_i = 1'b0;
  logic [15:0]   cmd_addr_i = '0;
  logic [1:0]    cmd_size_i = '0;
  logic [63:0]   cmd_data_i = '0;
  logic          resp_v_o;
  logic          resp_yumi_i = 1'b0;
  logic [63:0]   resp_data_o;
  logic          resp_err_o;
  logic [H-1:0]  software_irq_o, timer_irq_o, external_irq_o;

  bp_clint_nhart #(.harts_p(H), .ds_ratio_p(DS)) dut (
    .clk_i(clk), .reset_i(rst),
    .cmd_v_i(cmd_v_i), .cmd_ready_and_o(cmd_ready_and_o),
    .cmd_w_i(cmd_w_i), .cmd_addr_i(cmd_addr_i), .cmd_size_i(cmd_size_i),
    .cmd_data_i(cmd_data_i),
    .resp_v_o(resp_v_o), .resp_yumi_i(resp_yumi_i),
    .resp_data_o(resp_data_o), .resp_err_o(resp_err_o),
    .software_irq_o(software_irq_o), .timer_irq_o(timer_irq_o),
    .external_irq_o(external_irq_o)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: timed out (t=%0t)", name, $time);
  endtask

  // ---------------- reference model ----------------
  logic [63:0] m_mtime;
  logic [63:0] m_cmp [H];
  logic [H-1:0] m_msip, m_meip;
  int          m_edges;
  bit          m_resp_v;
  logic [64:0] exp_q[$];   // {err, data}

  // Classify an access by plain address arithmetic.
  // kind: 1 msip, 2 mtimecmp, 3 mtime, 4 meip
  function automatic void m_decode(input logic [15:0] a, input logic [1:0] sz,
                                   output bit err, output int kind,
                                   output int h, output bit hi);
    int ai, al;
    ai = int'(a);
    al = (sz == 2'd3) ? 8 : 4;
    err = 1; kind = 0; h = 0;
    hi = (ai % 8) >= 4;
    if (sz == 2'd2 || sz == 2'd3) begin
      if (ai < 'h4000) begin
        kind = 1; h = ai / 4;
        err = !(sz == 2'd2 && ai % 4 == 0 && h < H);
      end else if (ai < 'h8000) begin
        kind = 2; h = (ai - 'h4000) / 8;
        err = !(h < H && ai % al == 0);
      end else if (ai >= 'hBFF8 && ai < 'hC000) begin
        kind = 3;
        err = !(ai % al == 0);
      end else if (ai >= 'hC000) begin
        kind = 4; h = (ai - 'hC000) / 4;
        err = !(sz == 2'd2 && ai % 4 == 0 && h < H);
      end
    end
  endfunction

  function automatic logic [63:0] m_read64(input logic [63:0] v, input logic [1:0] sz, input bit hi);
    if (sz == 2'd3) return v;
    return hi ? (v >> 32) : (v & 64'hFFFF_FFFF);
  endfunction

  function automatic logic [63:0] m_write64(input logic [63:0] v, input logic [63:0] d,
                                            input logic [1:0] sz, input bit hi);
    if (sz == 2'd3) return d;
    return hi ? {d[31:0], v[31:0]} : {v[63:32], d[31:0]};
  endfunction

  always @(posedge clk) begin : model_b
    bit acc, tick, mt_wr, err, hi;
    int kind, h;
    logic [63:0] rd;
    if (rst) begin
      m_mtime = '0; m_msip = '0; m_meip = '0; m_edges = 0; m_resp_v = 0;
      for (int i = 0; i < H; i++) m_cmp[i] = '1;
      exp_q.delete();
    end else begin
      acc = cmd_v_i && (!m_resp_v || resp_yumi_i);
      if (m_resp_v && resp_yumi_i) m_resp_v = 0;
      m_edges++;
      tick  = (m_edges % DS) == 0;   // every DS-th edge since reset
      mt_wr = 0;
      if (acc) begin
        m_decode(cmd_addr_i, cmd_size_i, err, kind, h, hi);
        rd = '0;
        if (!err) begin
          case (kind)
            1: begin rd = 64'(m_msip[h]); if (cmd_w_i) m_msip[h] = cmd_data_i[0]; end
            2: begin
              rd = m_read64(m_cmp[h], cmd_size_i, hi);
              if (cmd_w_i) m_cmp[h] = m_write64(m_cmp[h], cmd_data_i, cmd_size_i, hi);
            end
            3: begin
              rd = m_read64(m_mtime, cmd_size_i, hi);
              if (cmd_w_i) begin
                m_mtime = m_write64(m_mtime, cmd_data_i, cmd_size_i, hi);
                mt_wr = 1;
              end
            end
            4: begin rd = 64'(m_meip[h]); if (cmd_w_i) m_meip[h] = cmd_data_i[0]; end
            default: ;
          endcase
        end
        if (cmd_w_i || err) rd = '0;
        exp_q.push_back({err, rd});
        m_resp_v = 1;
      end
      if (tick && !mt_wr) m_mtime = m_mtime + 64'd1;
    end
  end

  // ---------------- scoreboard / per-cycle checks ----------------
  always @(negedge clk) begin : sb_b
    logic [H-1:0] exp_t;
    logic [64:0]  e;
    if (rst) begin
      check("ready_in_reset", 64'(cmd_ready_and_o), 64'd0);
    end else begin
      for (int i = 0; i < H; i++) exp_t[i] = (m_mtime >= m_cmp[i]);
      check("cmd_ready", 64'(cmd_ready_and_o), 64'(!m_resp_v || resp_yumi_i));
      check("resp_v", 64'(resp_v_o), 64'(m_resp_v));
      check("timer_irq", 64'(timer_irq_o), 64'(exp_t));
      check("software_irq", 64'(software_irq_o), 64'(m_msip));
      check("external_irq", 64'(external_irq_o), 64'(m_meip));
      if (resp_v_o && resp_yumi_i) begin
        if (exp_q.size() == 0) fail_now("resp_unexpected");
        else begin
          e = exp_q.pop_front();
          check("resp_err", 64'(resp_err_o), 64'(e[64]));
          check("resp_data", resp_data_o, e[63:0]);
        end
      end
    end
  end

  // ---------------- driver ----------------
  // Entered and left at #1 after a rising edge.
  task automatic do_cmd(input bit w, input logic [15:0] a, input logic [1:0] sz,
                        input logic [63:0] d, input int yumi_delay,
                        output bit err, output logic [63:0] rd);
    bit got;
    err = 0; rd = '0;
    cmd_v_i = 1; cmd_w_i = w; cmd_addr_i = a; cmd_size_i = sz; cmd_data_i = d;
    got = 0;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      if (cmd_ready_and_o) got = 1;
      @(posedge clk); #1;
    end
    cmd_v_i = 0;
    if (!got) begin fail_now("accept"); return; end
    got = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (resp_v_o) begin got = 1; break; end
    end
    if (!got) begin fail_now("response"); return; end
    err = resp_err_o; rd = resp_data_o;
    @(posedge clk); #1;
    for (int i = 0; i < yumi_delay; i++) begin @(posedge clk); #1; end
    resp_yumi_i = 1;
    @(posedge clk); #1;
    resp_yumi_i = 0;
  endtask

  typedef struct {
    bit          w;
    logic [15:0] a;
    logic [1:0]  sz;
    logic [63:0] d;
    bit          e;
    logic [63:0] x;
  } vec_t;

  vec_t tbl[20];

  initial begin : watchdog_b
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : main_b
    bit          err;
    logic [63:0] rd;
    int          n;

    tbl[0]  = '{1'b1, 16'h0004, 2'd2, 64'd1, 1'b0, 64'd0};
    tbl[1]  = '{1'b1, 16'hC000, 2'd2, 64'd3, 1'b0, 64'd0};
    tbl[2]  = '{1'b0, 16'hC000, 2'd2, 64'd0, 1'b0, 64'd1};
    tbl[3]  = '{1'b0, 16'h0004, 2'd2, 64'd0, 1'b0, 64'd1};
    tbl[4]  = '{1'b0, 16'h0000, 2'd2, 64'd0, 1'b0, 64'd0};
    tbl[5]  = '{1'b0, 16'h0010, 2'd2, 64'd0, 1'b1, 64'd0};
    tbl[6]  = '{1'b0, 16'h0000, 2'd3, 64'd0, 1'b1, 64'd0};
    tbl[7]  = '{1'b0, 16'h4002, 2'd2, 64'd0, 1'b1, 64'd0};
    tbl[8]  = '{1'b1, 16'h0008, 2'd1, 64'd1, 1'b1, 64'd0};
    tbl[9]  = '{1'b1, 16'h0000, 2'd3, 64'd1, 1'b1, 64'd0};
    tbl[10] = '{1'b0, 16'h0000, 2'd2, 64'd0, 1'b0, 64'd0};
    tbl[11] = '{1'b1, 16'h4000, 2'd2, 64'h1234_5678, 1'b0, 64'd0};
    tbl[12] = '{1'b0, 16'h4004, 2'd2, 64'd0, 1'b0, 64'hFFFF_FFFF};
    tbl[13] = '{1'b0, 16'h4000, 2'd3, 64'd0, 1'b0, 64'hFFFF_FFFF_1234_5678};
    tbl[14] = '{1'b1, 16'h4020, 2'd3, 64'd5, 1'b1, 64'd0};
    tbl[15] = '{1'b0, 16'h8000, 2'd2, 64'd0, 1'b1, 64'd0};
    tbl[16] = '{1'b0, 16'hBFFC, 2'd3, 64'd0, 1'b1, 64'd0};
    tbl[17] = '{1'b1, 16'hC004, 2'd2, 64'd0, 1'b0, 64'd0};
    tbl[18] = '{1'b0, 16'h4018, 2'd3, 64'd0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF};
    tbl[19] = '{1'b1, 16'hC010, 2'd2, 64'd1, 1'b1, 64'd0};

    // Reset, then check the idle state just after deassertion
    repeat (3) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    check("reset_resp_v", 64'(resp_v_o), 64'd0);
    check("reset_ready", 64'(cmd_ready_and_o), 64'd1);
    check("reset_irqs", 64'({timer_irq_o, software_irq_o, external_irq_o}), 64'd0);

    // mtime after 8*DS idle cycles
    repeat (8 * DS - 1) @(posedge clk);
    @(posedge clk); #1;
    do_cmd(0, 16'hBFF8, 2'd3, 64'd0, 0, err, rd);
    check("mtime_idle_near_8", 64'(rd >= 64'd7 && rd <= 64'd9), 64'd1);
    check("mtime_idle_err", 64'(err), 64'd0);
    check("timer_irq_idle", 64'(timer_irq_o), 64'd0);

    // Table of directed accesses
    for (int i = 0; i < 20; i++) begin
      do_cmd(tbl[i].w, tbl[i].a, tbl[i].sz, tbl[i].d, i % 3, err, rd);
      check($sformatf("vec%0d_err", i), 64'(err), 64'(tbl[i].e));
      check($sformatf("vec%0d_data", i), rd, tbl[i].x);
    end
    @(negedge clk);
    check("sw_irq_pattern", 64'(software_irq_o), 64'b0010);
    check("ext_irq_pattern", 64'(external_irq_o), 64'b0001);
    @(posedge clk); #1;

    // Timer interrupt on hart 2, then cleared by an upper-half write
    do_cmd(1, 16'h4010, 2'd3, 64'h20, 0, err, rd);
    n = 0;
    while (m_mtime < 64'h20 && n < 1000) begin @(posedge clk); #1; n++; end
    if (n >= 1000) fail_now("wait_mtime_0x20");
    @(negedge clk);
    check("timer_irq_hart2", 64'(timer_irq_o), 64'b0100);
    @(posedge clk); #1;
    do_cmd(1, 16'h4014, 2'd2, 64'hFFFF_FFFF, 0, err, rd);
    @(negedge clk);
    check("timer_irq_cleared", 64'(timer_irq_o), 64'd0);
    @(posedge clk); #1;

    // mtime wrap
    do_cmd(1, 16'hBFF8, 2'd3, 64'hFFFF_FFFF_FFFF_FFFF, 0, err, rd);
    repeat (DS) @(posedge clk);
    #1;
    do_cmd(0, 16'hBFF8, 2'd3, 64'd0, 0, err, rd);
    check("mtime_wrapped", 64'(rd <= 64'd1), 64'd1);
    check("timer_irq_after_wrap", 64'(timer_irq_o), 64'd0);

    // Back-to-back reads with yumi held, then a stalled response
    cmd_v_i = 1; cmd_w_i = 0; cmd_addr_i = 16'hC000; cmd_size_i = 2'd2; resp_yumi_i = 1;
    @(posedge clk); #1;
    cmd_addr_i = 16'h0004;
    @(negedge clk);
    check("b2b_ready", 64'(cmd_ready_and_o), 64'd1);
    check("b2b_first_data", resp_data_o, 64'd1);
    @(posedge clk); #1;
    cmd_v_i = 0;
    @(negedge clk);
    check("b2b_second_valid", 64'(resp_v_o), 64'd1);
    check("b2b_second_data", resp_data_o, 64'd1);
    @(posedge clk); #1;
    resp_yumi_i = 0; cmd_v_i = 1; cmd_addr_i = 16'h4010; cmd_size_i = 2'd3;
    @(posedge clk); #1;
    cmd_addr_i = 16'h0000; cmd_size_i = 2'd2;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("stall_ready_low", 64'(cmd_ready_and_o), 64'd0);
      check("stall_data_stable", resp_data_o, 64'hFFFF_FFFF_0000_0020);
      @(posedge clk); #1;
    end
    resp_yumi_i = 1;
    @(posedge clk); #1;
    cmd_v_i = 0;
    @(posedge clk); #1;
    resp_yumi_i = 0;

    // Randomized traffic against the model
    for (int i = 0; i < 250; i++) begin
      logic [15:0] a;
      logic [1:0]  sz;
      case ($urandom_range(0, 5))
        0: a = 16'(4 * $urandom_range(0, 5));
        1: a = 16'('h4000 + 8 * $urandom_range(0, 5) + 4 * $urandom_range(0, 1));
        2: a = 16'('hBFF8 + 4 * $urandom_range(0, 1));
        3: a = 16'('hC000 + 4 * $urandom_range(0, 5));
        4: a = 16'($urandom_range(0, 65535));
        default: a = 16'('h4000 + $urandom_range(0, 47));
      endcase
      sz = ($urandom_range(0, 9) == 0) ? 2'($urandom_range(0, 1)) : 2'($urandom_range(2, 3));
      do_cmd(bit'($urandom_range(0, 1)), a, sz, {$urandom, $urandom},
             $urandom_range(0, 2), err, rd);
    end

    // Reset with a response in flight
    do_cmd(1, 16'h0000, 2'd2, 64'd1, 0, err, rd);
    cmd_v_i = 1; cmd_w_i = 0; cmd_addr_i = 16'hC000; cmd_size_i = 2'd2;
    @(posedge clk); #1;
    cmd_v_i = 0;
    @(negedge clk);
    check("inflight_valid", 64'(resp_v_o), 64'd1);
    rst = 1;
    @(posedge clk); #1;
    @(negedge clk);
    check("reset_drops_resp", 64'(resp_v_o), 64'd0);
    @(posedge clk); #1;
    rst = 0;
    @(posedge clk); #1;
    @(negedge clk);
    check("post_reset_irqs", 64'({timer_irq_o, software_irq_o, external_irq_o}), 64'd0);
    check("post_reset_resp_v", 64'(resp_v_o), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/bp_clint_nhart.md
BP_CLINT_NHART -- requirements
Module: bp_clint_nhart

Interface
REQ-001 SHALL have parameter harts_p, default 4, number of harts served (1..16).
REQ-002 SHALL have parameter ds_ratio_p, default 8, core clocks per mtime increment (2..255).
REQ-003 SHALL have port clk_i  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port reset_i  input  1  synchronous active-high reset.
REQ-005 SHALL have port cmd_v_i  input  1  command valid.
REQ-006 SHALL have port cmd_ready_and_o  output  1  command ready; accepted when cmd_v_i & cmd_ready_and_o.
REQ-007 SHALL have port cmd_w_i  input  1  1=write, 0=read.
REQ-008 SHALL have port cmd_addr_i  input  16  byte offset within device.
REQ-009 SHALL have port cmd_size_i  input  2  2=4 bytes, 3=8 bytes; others illegal.
REQ-010 SHALL have port cmd_data_i  input  64  write data, LSB-aligned.
REQ-011 SHALL have port resp_v_o  output  1  response valid.
REQ-012 SHALL have port resp_yumi_i  input  1  response consumed; only legal when resp_v_o=1.
REQ-013 SHALL have port resp_data_o  output  64  read data; 0 for writes and errors.
REQ-014 SHALL have port resp_err_o  output  1  illegal address, size or alignment.
REQ-015 SHALL have ports software_irq_o, timer_irq_o, external_irq_o  output  harts_p each  per-hart interrupt lines.

Function
REQ-016 SHALL decode: msip[h] at 0x0000+4h (4B); mtimecmp[h] at 0x4000+8h (8B, or 4B halves at +0/+4); mtime at 0xBFF8 (8B, or 4B halves); meip[h] at 0xC000+4h (4B); h<harts_p.
REQ-017 SHALL flag error on unmapped address, h>=harts_p, size not 2/3, 8B access not 8-aligned, or 8B access to msip/meip.
REQ-018 SHALL hold one response register; cmd_ready_and_o = ~resp_v_o | resp_yumi_i (back-to-back at one command per cycle).
REQ-019 SHALL assert resp_v_o the cycle after acceptance and hold resp_data_o/resp_err_o stable until resp_yumi_i.
REQ-020 SHALL sample read data at the acceptance edge (pre-write value of same-cycle state).
REQ-021 SHALL commit writes at the acceptance edge; errored commands change no state.
REQ-022 SHALL store only bit 0 of write data for msip/meip; reads return it zero-extended.
REQ-023 SHALL write a 4B half of a 64-bit register without altering the other half; 4B reads return that half in resp_data_o[31:0], upper bits 0.
REQ-024 SHALL increment mtime by 1 (mod 2^64, wrapping to 0) once every ds_ratio_p cycles via a free-running prescaler.
REQ-025 SHALL give a mtime write priority over a same-cycle increment; prescaler is not reset by the write.
REQ-026 SHALL drive timer_irq_o[h] = (mtime >= mtimecmp[h]) unsigned, combinationally from registered state.
REQ-027 SHALL drive software_irq_o[h] = msip[h], external_irq_o[h] = meip[h].

Reset
REQ-028 SHALL on reset_i: mtime=0, prescaler=0, every mtimecmp=all-ones, msip=0, meip=0, resp_v_o=0.
REQ-029 SHALL hold cmd_ready_and_o=0 while reset_i=1 and drop any in-flight response.
REQ-030 SHALL have all interrupt outputs 0 in the first cycle after reset deassertion.

Verification
REQ-031 Reset, idle 8*ds_ratio_p cycles, 8B read 0xBFF8 -> resp_data_o=8 (+/-1), timer_irq_o=0.
REQ-032 Write mtimecmp[2]=0x20 (8B), wait until mtime>=0x20 -> only timer_irq_o[2]=1; write 0xFFFFFFFF to 0x4014 -> irq drops next cycle.
REQ-033 Write 0x1 to 0x0004, 0x3 to 0xC000 -> software_irq_o=4'b0010, external_irq_o=4'b0001; read 0xC000 -> 1.
REQ-034 Write mtime=0xFFFF_FFFF_FFFF_FFFF, wait ds_ratio_p cycles -> mtime reads 0, timer_irq_o all 0.
REQ-035 Read 0x0010 (harts_p=4), 8B read 0x0000, 4B read 0x4002 -> resp_err_o=1, data 0, no state change.
REQ-036 Two back-to-back reads with resp_yumi_i held 1 -> one response per cycle; with resp_yumi_i=0 -> cmd_ready_and_o=0, response stable.
